// File: rtl/lane_prune_stream.sv
// NEAT genome delete-mutation stage: drops hidden nodes and connections,
// tracking deleted node IDs so dependent connections are pruned too.
module lane_prune_stream #(
    parameter  int GENE_SZ   = 64,
    parameter  int ATTR_SZ   = 8,
    parameter  int DEL_DEPTH = 16,
    parameter  int CNT_W     = 8,
    localparam int CW        = $clog2(DEL_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               genome_start,
    input  logic [1:0]         state,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GENE_SZ-1:0] gene_in,
    input  logic [ATTR_SZ-1:0] node_del_prob,
    input  logic [ATTR_SZ-1:0] conn_del_prob,
    input  logic [ATTR_SZ-1:0] random,
    output logic [GENE_SZ-1:0] gene_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      del_node_cnt,
    output logic [CNT_W-1:0]   del_conn_cnt,
    output logic               list_full
);

    logic [ATTR_SZ-1:0] r_list [DEL_DEPTH];
    logic [CW-1:0]      r_node_cnt;
    logic [CNT_W-1:0]   r_conn_cnt;
    logic [GENE_SZ-1:0] r_out;
    logic               r_valid;

    logic [ATTR_SZ-1:0] w_src;
    logic [ATTR_SZ-1:0] w_dst;
    logic [1:0]         w_type;
    logic [CW-1:0]      w_base_cnt;
    logic [CNT_W-1:0]   w_base_conn;
    logic               w_full;
    logic               w_src_hit;
    logic               w_dst_hit;
    logic               w_acc;
    logic               w_node_del;
    logic               w_conn_del;
    logic               w_keep;
    logic               w_add;
    logic               w_cdel;

    assign w_src  = gene_in[6*ATTR_SZ-1:5*ATTR_SZ];
    assign w_dst  = gene_in[5*ATTR_SZ-1:4*ATTR_SZ];
    assign w_type = gene_in[7*ATTR_SZ-2:7*ATTR_SZ-3];

    assign in_ready = !r_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    // A coincident genome_start makes the current beat see an empty list.
    assign w_base_cnt  = genome_start ? '0 : r_node_cnt;
    assign w_base_conn = genome_start ? '0 : r_conn_cnt;
    assign w_full      = (w_base_cnt == CW'(DEL_DEPTH));

    always_comb begin
        w_src_hit = 1'b0;
        w_dst_hit = 1'b0;
        for (int i = 0; i < DEL_DEPTH; i++) begin
            if (CW'(i) < w_base_cnt) begin
                if (r_list[i] == w_src) w_src_hit = 1'b1;
                if (r_list[i] == w_dst) w_dst_hit = 1'b1;
            end
        end
    end

    assign w_node_del = (random > node_del_prob) && (w_type == 2'b00)
                        && !w_full;
    assign w_conn_del = w_src_hit || w_dst_hit
                        || (random > conn_del_prob);

    always_comb begin
        w_keep = 1'b0;
        unique case (state)
            2'b00:   w_keep = !w_node_del;
            2'b10:   w_keep = !w_conn_del;
            2'b01:   w_keep = 1'b1;
            default: w_keep = 1'b0;
        endcase
    end

    // Duplicates are still dropped but never occupy a second slot.
    assign w_add  = w_acc && (state == 2'b00) && w_node_del && !w_src_hit;
    assign w_cdel = w_acc && (state == 2'b10) && w_conn_del;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_node_cnt <= '0;
            r_conn_cnt <= '0;
            for (int i = 0; i < DEL_DEPTH; i++) r_list[i] <= '0;
        end else begin
            if (in_ready) begin
                r_valid <= w_acc && w_keep;
                r_out   <= (w_acc && w_keep) ? gene_in : '0;
            end
            r_node_cnt <= w_add ? w_base_cnt + CW'(1) : w_base_cnt;
            for (int i = 0; i < DEL_DEPTH; i++) begin
                if (w_add && (w_base_cnt == CW'(i))) r_list[i] <= w_src;
            end
            if (w_cdel && !(&w_base_conn))
                r_conn_cnt <= w_base_conn + CNT_W'(1);
            else
                r_conn_cnt <= w_base_conn;
        end
    end

    assign gene_out     = r_out;
    assign out_valid    = r_valid;
    assign del_node_cnt = r_node_cnt;
    assign del_conn_cnt = r_conn_cnt;
    assign list_full    = (r_node_cnt == CW'(DEL_DEPTH));

endmodule
